smi_frame_arbiter_x2: RTL and testbench
=======================================

Name: smi_frame_arbiter_x2

Overview:
- Two-input SMI frame arbiter that merges the request outputs of two transaction matchers onto one shared SMI request channel.
- Arbitration is per frame and round-robin. Once a frame is granted, all of its flits pass contiguously, with no interleaving between inputs.
- Sits directly downstream of the transaction matcher request outputs. Responses are returned using the matchers' fixed tag fields, so this block never modifies data.

Parameters:
- FlitWidth, 4, flit width in bytes; must be at least 4.
- DataWidth, FlitWidth*8, derived data port width in bits.
- EofcMask, 2*FlitWidth-1, derived mask applied to incoming eofc values.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- smiInAReady  in  1  input A flit valid.
- smiInAEofc  in  8  input A end-of-frame control; nonzero marks the last flit.
- smiInAData  in  DataWidth  input A flit data.
- smiInAStop  out  1  input A backpressure.
- smiInBReady, smiInBEofc, smiInBData, smiInBStop  same as A, for input B.
- smiOutReady  out  1  output flit valid.
- smiOutEofc  out  8  output end-of-frame control.
- smiOutData  out  DataWidth  output flit data.
- smiOutStop  in  1  output backpressure.

Behaviour:
- Handshake: a flit transfers on a cycle where Ready=1 and Stop=0. A flit with Ready=1 and Stop=1 is held unchanged until it transfers.
- Input stage, per port:
  - Ready register resets to 0. Eofc/data registers are not reset.
  - Registers load when ~(Ready_q & Halt).
  - Eofc is masked with EofcMask on load.
  - Stop output = Ready_q & Halt.
- Output stage: a double-buffer register pair, reset empty, so smiOutReady=0 after reset. It accepts a flit when its internal stop is 0.
- Latency: 2 cycles from a flit being accepted at an input to it appearing on smiOut, when the path is uncongested.
- Clock and reset: one clock; reset is synchronous and active-high (clk, srst).
- State machine. State resets to Idle; priority pointer prio resets to 0 (A preferred).
  - Idle:
    - If exactly one input has Ready_q=1, grant that input.
    - If both have Ready_q=1, grant the input selected by prio.
    - On a grant, the first flit is forwarded in the same cycle. The state becomes TransferA/TransferB, or stays Idle if the first flit is also the last (eofc≠0) and it transfers.
    - The ungranted input stays halted.
  - TransferA/TransferB:
    - Output buffer Ready = granted input Ready_q.
    - Granted input Halt = output buffer stop.
    - The other input is always halted.
    - When a flit with eofc≠0 transfers, return to Idle.
  - Idle with no request: both inputs halted, buffer Ready=0.
- Fairness:
  - prio updates when a frame's last flit transfers: it points to the input that was not just served.
  - With both inputs continuously requesting, frames alternate A,B,A,B.
- Single-flit frames transfer back-to-back at 1 frame/cycle, still alternating under contention.
- Bubbles: gaps (Ready_q=0) inside a granted frame hold the grant and do not reopen arbitration.
- Backpressure: smiOutStop held high fills the output buffer. After that, the granted input's Stop asserts within 2 cycles and no flit is lost or duplicated.
- Reset mid-frame:
  - State returns to Idle and prio to 0. Output buffer and input Ready registers clear.
  - The partial frame is discarded; upstream is reset by the same srst.
- Data and eofc pass unmodified. Tag bits are never altered.

Decomposition:
- Shared package/constants:
  - state encodings ArbIdle=0, ArbTransferA=1, ArbTransferB=2;
  - eofc mask derivation;
  - SMI flit field positions (tag at data[31:16]).
- One sub-module: smi_self_link_double_buffer, width DataWidth+8, carrying {eofc, data}. It is shared with other SMI blocks.
- Input registers stay inline, two instances of the same logic.

Test Plan:
- Reset: hold srst 3 cycles with both inputs Ready=1 -> smiOutReady=0 and both Stops=0 during reset. The first output after release is A's flit, 2 cycles after release.
- Contention: A and B each present 4-flit frames continuously (eofc=0,0,0,4; FlitWidth=4) -> output frames A,B,A,B, each 4 contiguous flits with no interleave. Tag data[31:16] is unchanged (e.g. 0x0401 from A, 0x0802 from B).
- Single-flit frames: both inputs send eofc=4 frames every cycle, smiOutStop=0 -> output alternates A,B every cycle at full throughput.
- Backpressure: smiOutStop=1 for 10 cycles mid-frame -> granted input Stop=1 within 2 cycles. After release, all flits are delivered in order with no loss or duplication.
- Bubble: A's frame has a 3-cycle Ready gap mid-frame while B requests -> B is not granted until A's eofc≠0 flit transfers.
- Reset mid-frame: assert srst during flit 2 of a 4-flit A frame -> output empties and prio=0. A fresh B-only frame after reset is passed intact.

Source files
------------

// File: rtl/smi_frame_arbiter_x2_pkg.sv
// Shared SMI arbiter definitions: arbitration states, flit field positions
// and the eofc mask derived from the flit width.
package smi_frame_arbiter_x2_pkg;

    typedef enum logic [1:0] {
        ArbIdle      = 2'd0,
        ArbTransferA = 2'd1,
        ArbTransferB = 2'd2
    } arb_state_e;

    localparam int SmiEofcWidth = 8;
    localparam int SmiTagLsb    = 16;
    localparam int SmiTagMsb    = 31;

    // Only the byte-count bits that can be meaningful for this flit width survive.
    function automatic logic [SmiEofcWidth-1:0] eofc_mask(input int flitWidth);
        return SmiEofcWidth'(2 * flitWidth - 1);
    endfunction

endpackage

// File: rtl/smi_self_link_double_buffer.sv
// Two-entry registered pipeline stage for an SMI link: full throughput with a
// registered upstream stop, so backpressure never forms a combinational path.
module smi_self_link_double_buffer #(
    parameter int Width = 40
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_inReady,
    input  logic [Width-1:0] i_inData,
    output logic             o_inStop,
    output logic             o_outReady,
    output logic [Width-1:0] o_outData,
    input  logic             i_outStop
);

    logic             r_mainVld;
    logic             r_skidVld;
    logic [Width-1:0] r_mainData;
    logic [Width-1:0] r_skidData;
    logic             w_mainFree;

    assign w_mainFree = ~r_mainVld | ~i_outStop;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_mainVld <= 1'b0;
            r_skidVld <= 1'b0;
        end else if (w_mainFree) begin
            r_mainVld <= r_skidVld | i_inReady;
            r_skidVld <= 1'b0;
        end else if (i_inReady & ~r_skidVld) begin
            r_skidVld <= 1'b1;
        end
    end

    // The skid entry only captures while empty; upstream is stopped once it holds a flit.
    always_ff @(posedge i_clk) begin
        if (w_mainFree) begin
            r_mainData <= r_skidVld ? r_skidData : i_inData;
        end
        if (~r_skidVld) begin
            r_skidData <= i_inData;
        end
    end

    assign o_inStop   = r_skidVld;
    assign o_outReady = r_mainVld;
    assign o_outData  = r_mainData;

endmodule

// File: rtl/smi_frame_arbiter_x2.sv
// Merges two SMI request streams onto one channel with per-frame round-robin
// arbitration; a granted frame passes contiguously and flits are never altered.
module smi_frame_arbiter_x2
    import smi_frame_arbiter_x2_pkg::*;
#(
    parameter int                      FlitWidth = 4,
    parameter int                      DataWidth = FlitWidth * 8,
    parameter logic [SmiEofcWidth-1:0] EofcMask  = eofc_mask(FlitWidth)
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    smiInAReady,
    input  logic [SmiEofcWidth-1:0] smiInAEofc,
    input  logic [DataWidth-1:0]    smiInAData,
    output logic                    smiInAStop,
    input  logic                    smiInBReady,
    input  logic [SmiEofcWidth-1:0] smiInBEofc,
    input  logic [DataWidth-1:0]    smiInBData,
    output logic                    smiInBStop,
    output logic                    smiOutReady,
    output logic [SmiEofcWidth-1:0] smiOutEofc,
    output logic [DataWidth-1:0]    smiOutData,
    input  logic                    smiOutStop
);

    localparam int BufWidth = DataWidth + SmiEofcWidth;

    logic                    r_aReady;
    logic [SmiEofcWidth-1:0] r_aEofc;
    logic [DataWidth-1:0]    r_aData;
    logic                    r_bReady;
    logic [SmiEofcWidth-1:0] r_bEofc;
    logic [DataWidth-1:0]    r_bData;

    arb_state_e r_state;
    arb_state_e w_nextState;
    logic       r_prio;
    logic       w_nextPrio;

    logic                w_aHalt;
    logic                w_bHalt;
    logic                w_aLast;
    logic                w_bLast;
    logic                w_selB;
    logic                w_bufReady;
    logic                w_bufStop;
    logic [BufWidth-1:0] w_bufData;
    logic [BufWidth-1:0] w_outData;

    // Input registers: a held flit stays put while the arbiter halts its port.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_aReady <= 1'b0;
            r_bReady <= 1'b0;
        end else begin
            if (~(r_aReady & w_aHalt)) r_aReady <= smiInAReady;
            if (~(r_bReady & w_bHalt)) r_bReady <= smiInBReady;
        end
    end

    always_ff @(posedge clk) begin
        if (~(r_aReady & w_aHalt)) begin
            r_aEofc <= smiInAEofc & EofcMask;
            r_aData <= smiInAData;
        end
        if (~(r_bReady & w_bHalt)) begin
            r_bEofc <= smiInBEofc & EofcMask;
            r_bData <= smiInBData;
        end
    end

    assign smiInAStop = r_aReady & w_aHalt;
    assign smiInBStop = r_bReady & w_bHalt;
    assign w_aLast    = (r_aEofc != '0);
    assign w_bLast    = (r_bEofc != '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ArbIdle;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_prio  <= w_nextPrio;
        end
    end

    // prio names the input preferred next time both request: 0 = A, 1 = B.
    always_comb begin
        w_nextState = r_state;
        w_nextPrio  = r_prio;
        w_aHalt     = 1'b1;
        w_bHalt     = 1'b1;
        w_bufReady  = 1'b0;
        w_selB      = 1'b0;
        case (r_state)
            ArbIdle: begin
                if (r_aReady & (~r_bReady | ~r_prio)) begin
                    w_bufReady = 1'b1;
                    w_aHalt    = w_bufStop;
                    if (w_aLast & ~w_bufStop) w_nextPrio  = 1'b1;
                    else                      w_nextState = ArbTransferA;
                end else if (r_bReady) begin
                    w_selB     = 1'b1;
                    w_bufReady = 1'b1;
                    w_bHalt    = w_bufStop;
                    if (w_bLast & ~w_bufStop) w_nextPrio  = 1'b0;
                    else                      w_nextState = ArbTransferB;
                end
            end
            ArbTransferA: begin
                w_bufReady = r_aReady;
                w_aHalt    = w_bufStop;
                if (r_aReady & w_aLast & ~w_bufStop) begin
                    w_nextState = ArbIdle;
                    w_nextPrio  = 1'b1;
                end
            end
            ArbTransferB: begin
                w_selB     = 1'b1;
                w_bufReady = r_bReady;
                w_bHalt    = w_bufStop;
                if (r_bReady & w_bLast & ~w_bufStop) begin
                    w_nextState = ArbIdle;
                    w_nextPrio  = 1'b0;
                end
            end
            default: w_nextState = ArbIdle;
        endcase
    end

    assign w_bufData = w_selB ? {r_bEofc, r_bData} : {r_aEofc, r_aData};

    smi_self_link_double_buffer #(
        .Width (BufWidth)
    ) u_outBuf (
        .i_clk      (clk),
        .i_srst     (srst),
        .i_inReady  (w_bufReady),
        .i_inData   (w_bufData),
        .o_inStop   (w_bufStop),
        .o_outReady (smiOutReady),
        .o_outData  (w_outData),
        .i_outStop  (smiOutStop)
    );

    assign {smiOutEofc, smiOutData} = w_outData;

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// Randomized bench for smi_frame_arbiter_x2: per-source scoreboards plus a
// frame-level round-robin model check ordering, contiguity, masking and backpressure.
module tb_smi_frame_arbiter_x2;
    import smi_frame_arbiter_x2_pkg::*;

    localparam int         FW        = 4;
    localparam logic [7:0] EOFC_KEEP = 8'(2 * FW - 1);

    typedef struct {
        logic [31:0] data;
        logic [7:0]  eofc;
        int          gap;
    } flit_t;

    logic        clk;
    logic        srst;
    logic        smiInAReady, smiInBReady;
    logic [7:0]  smiInAEofc, smiInBEofc;
    logic [31:0] smiInAData, smiInBData;
    logic        smiInAStop, smiInBStop;
    logic        smiOutReady;
    logic [7:0]  smiOutEofc;
    logic [31:0] smiOutData;
    logic        smiOutStop;

    smi_frame_arbiter_x2 #(.FlitWidth(FW)) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInAReady (smiInAReady),
        .smiInAEofc  (smiInAEofc),
        .smiInAData  (smiInAData),
        .smiInAStop  (smiInAStop),
        .smiInBReady (smiInBReady),
        .smiInBEofc  (smiInBEofc),
        .smiInBData  (smiInBData),
        .smiInBStop  (smiInBStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    flit_t       txA[$], txB[$], expA[$], expB[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, frameCnt = 0, openSrc = -1, inFiresA = 0;
    int          stopProb = 0, stopFrom = -1000, stopTo = -1000, idleGaps = 0;
    bit          modelPrio = 1'b0, altMode = 1'b0, fullMode = 1'b0, bpSrc = 1'b0;
    bit          presA = 1'b0, presB = 1'b0, prevHeld = 1'b0, seenOut = 1'b0;
    logic [40:0] prevOut = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pending();
        return txA.size() + txB.size() + expA.size() + expB.size();
    endfunction

    task automatic gen_frame(input int src, input int len, input bit gaps);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.data = {(src == 1) ? 8'h08 : 8'h04, frameCnt[7:0], 16'($urandom)};
            f.eofc = {5'($urandom), (i == len - 1) ? 3'($urandom_range(1, 7)) : 3'b000};
            f.gap  = (gaps && $urandom_range(0, 99) < 20) ? int'($urandom_range(1, 3)) : 0;
            if (src == 1) txB.push_back(f);
            else          txA.push_back(f);
        end
        frameCnt++;
    endtask

    task automatic monitor_out();
        flit_t       f;
        logic [15:0] tag;
        int          src;
        tag = smiOutData[SmiTagMsb:SmiTagLsb];
        src = (tag[15:8] == 8'h08) ? 1 : 0;
        if ((src == 1 && expB.size() == 0) || (src == 0 && expA.size() == 0)) begin
            check_val("out_extra", {smiOutEofc, smiOutData}, 64'd0);
            return;
        end
        f = (src == 1) ? expB.pop_front() : expA.pop_front();
        check_val("out_flit", {smiOutEofc, smiOutData}, {f.eofc & EOFC_KEEP, f.data});
        if (openSrc >= 0)  check_val("no_interleave", src, openSrc);
        else if (altMode)  check_val("rr_order", src, modelPrio);
        if ((f.eofc & EOFC_KEEP) != 8'd0) begin
            openSrc   = -1;
            modelPrio = (src == 0);
        end else begin
            openSrc = src;
        end
    endtask

    task automatic step();
        logic aFire, bFire, oFire;
        @(negedge clk);
        if (prevHeld) check_val("out_hold", {smiOutReady, smiOutEofc, smiOutData}, prevOut);
        oFire    = smiOutReady & ~smiOutStop;
        prevHeld = smiOutReady & smiOutStop;
        prevOut  = {smiOutReady, smiOutEofc, smiOutData};
        if (oFire) begin
            seenOut = 1'b1;
            monitor_out();
        end else if (fullMode && seenOut && pending() > 0) begin
            idleGaps++;
        end
        if (cyc >= stopFrom + 2 && cyc < stopTo)
            check_val("bp_stop", bpSrc ? smiInBStop : smiInAStop, 1);
        aFire = smiInAReady & ~smiInAStop & (txA.size() > 0);
        bFire = smiInBReady & ~smiInBStop & (txB.size() > 0);
        if (aFire) begin
            expA.push_back(txA[0]);
            inFiresA++;
        end
        if (bFire) expB.push_back(txB[0]);
        @(posedge clk);
        #1;
        cyc++;
        if (aFire) begin void'(txA.pop_front()); presA = 1'b0; end
        if (bFire) begin void'(txB.pop_front()); presB = 1'b0; end
        if (!presA) begin
            if (txA.size() > 0 && txA[0].gap > 0) begin
                txA[0].gap = txA[0].gap - 1;
                smiInAReady = 1'b0;
            end else if (txA.size() > 0) begin
                presA = 1'b1; smiInAReady = 1'b1;
                smiInAData = txA[0].data; smiInAEofc = txA[0].eofc;
            end else smiInAReady = 1'b0;
        end
        if (!presB) begin
            if (txB.size() > 0 && txB[0].gap > 0) begin
                txB[0].gap = txB[0].gap - 1;
                smiInBReady = 1'b0;
            end else if (txB.size() > 0) begin
                presB = 1'b1; smiInBReady = 1'b1;
                smiInBData = txB[0].data; smiInBEofc = txB[0].eofc;
            end else smiInBReady = 1'b0;
        end
        smiOutStop = (cyc >= stopFrom && cyc < stopTo) ? 1'b1 : ($urandom_range(0, 99) < stopProb);
    endtask

    task automatic run_phase(input int maxCyc);
        int n = 0;
        idleGaps = 0;
        seenOut  = 1'b0;
        while (pending() > 0 && n < maxCyc) begin
            step();
            n++;
        end
        check_val("phase_done", pending(), 0);
        repeat (3) step();
        check_val("frame_closed", openSrc, -1);
        if (fullMode) check_val("full_rate_gaps", idleGaps, 0);
    endtask

    task automatic do_reset(input int n);
        srst = 1'b1;
        smiInAReady = 1'b0; smiInBReady = 1'b0; smiOutStop = 1'b0;
        txA.delete(); txB.delete(); expA.delete(); expB.delete();
        presA = 1'b0; presB = 1'b0; prevHeld = 1'b0;
        openSrc = -1; modelPrio = 1'b0;
        repeat (n) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check_val("post_rst_out_ready", smiOutReady, 0);
        check_val("post_rst_a_stop", smiInAStop, 0);
    endtask

    initial begin
        srst = 1'b1; smiOutStop = 1'b0;
        smiInAReady = 1'b1; smiInAEofc = 8'h04; smiInAData = 32'h0401_1234;
        smiInBReady = 1'b1; smiInBEofc = 8'h04; smiInBData = 32'h0802_5678;

        // Reset held with both inputs requesting; A wins first after release.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_val("rst_out_ready", smiOutReady, 0);
            check_val("rst_a_stop", smiInAStop, 0);
            check_val("rst_b_stop", smiInBStop, 0);
        end
        srst = 1'b0;
        @(posedge clk);
        #1 smiInAReady = 1'b0; smiInBReady = 1'b0;
        @(negedge clk);
        check_val("rst_lat1_empty", smiOutReady, 0);
        @(negedge clk);
        check_val("rst_first_ready", smiOutReady, 1);
        check_val("rst_first_is_a", {smiOutEofc, smiOutData}, {8'h04, 32'h0401_1234});
        @(negedge clk);
        check_val("rst_second_ready", smiOutReady, 1);
        check_val("rst_second_is_b", {smiOutEofc, smiOutData}, {8'h04, 32'h0802_5678});
        do_reset(2);

        // Contention with 4-flit frames at full rate.
        altMode = 1'b1; fullMode = 1'b1; stopProb = 0;
        for (int i = 0; i < 4; i++) begin gen_frame(0, 4, 1'b0); gen_frame(1, 4, 1'b0); end
        run_phase(300);

        // Single-flit frames, one per cycle, alternating.
        for (int i = 0; i < 8; i++) begin gen_frame(0, 1, 1'b0); gen_frame(1, 1, 1'b0); end
        run_phase(300);

        // Ten-cycle output stall in the middle of B-only traffic.
        altMode = 1'b0; fullMode = 1'b0;
        for (int i = 0; i < 4; i++) gen_frame(1, 4, 1'b0);
        bpSrc = 1'b1; stopFrom = cyc + 6; stopTo = cyc + 16;
        run_phase(300);
        stopFrom = -1000; stopTo = -1000;

        // Bubble inside A's frame while B waits.
        altMode = 1'b1;
        gen_frame(0, 4, 1'b0);
        txA[2].gap = 3;
        gen_frame(1, 4, 1'b0);
        run_phase(200);

        // Random lengths, gaps and output stalls.
        altMode = 1'b0; stopProb = 30;
        for (int i = 0; i < 12; i++) begin
            gen_frame(0, int'($urandom_range(1, 5)), 1'b1);
            gen_frame(1, int'($urandom_range(1, 5)), 1'b1);
        end
        run_phase(3000);

        // Reset during the second flit of A's second frame (prio was pointing at B).
        stopProb = 0;
        gen_frame(0, 4, 1'b0); gen_frame(0, 4, 1'b0);
        inFiresA = 0;
        for (int n = 0; n < 200 && inFiresA < 6; n++) step();
        check_val("midrst_reached", inFiresA, 6);
        do_reset(2);
        altMode = 1'b1;
        for (int i = 0; i < 2; i++) begin gen_frame(0, 3, 1'b0); gen_frame(1, 3, 1'b0); end
        run_phase(300);
        altMode = 1'b0;
        gen_frame(1, 4, 1'b0);
        run_phase(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
